large_array_mem: RTL and testbench
==================================

// Module: large_array_mem
// PURPOSE
//   RTL storage engine behind the LargeArray READ/WRITE instructions: a DEPTH x DATA_W register array
//   with a registered read port and a write port.
//   Sits directly under the instruction-level model; its odata is the value checked against the READ
//   instruction's odata.
//   After reset it runs a clear sequencer that writes INIT_VAL to every entry before accepting commands.
//   It keeps a saturating count of accepted reads for start/progress properties.
// PARAMETERS
//   DATA_W    8     width of each array entry and of data/odata
//   ADDR_W    4     address width; DEPTH = 2**ADDR_W (16 by default), so every address is legal
//   INIT_VAL  8'h00 value written to every entry by the clear sequencer
// PORTS
//   clk        in   1        single clock; all state updates on posedge
//   rst        in   1        synchronous, active-low reset (sampled on posedge clk)
//   ren        in   1        read command; accepted only when busy==0
//   wen        in   1        write command; accepted only when busy==0
//   addr       in   ADDR_W   shared read/write address
//   data       in   DATA_W   write data
//   busy       out  1        1 while the clear sequencer runs; commands are ignored
//   odata      out  DATA_W   registered read data
//   ovalid     out  1        one-cycle pulse: odata was updated by a read accepted last cycle
//   rd_count   out  8        accepted reads, saturating at 255
// BEHAVIOUR
//   Reset (rst==0 at posedge):
//     - state <= CLEAR, clr_ptr <= 0, busy <= 1, odata <= 0, ovalid <= 0, rd_count <= 0.
//     - Array contents are not reset directly; the sequencer overwrites them.
//   FSM states:
//     - CLEAR: each cycle array[clr_ptr] <= INIT_VAL, clr_ptr++. When clr_ptr==DEPTH-1 is written,
//       the next state is IDLE and busy <= 0. Clearing takes DEPTH cycles after reset deasserts
//       (16 by default).
//     - IDLE: commands are accepted. The FSM stays in IDLE until the next reset.
//   Read (IDLE, ren==1): odata <= array[addr] at this posedge; ovalid==1 in the following cycle only.
//     Latency is 1 clock.
//   No read: odata holds its previous value; ovalid==0.
//   Write (IDLE, wen==1): array[addr] <= data at this posedge; visible to reads from the next cycle.
//   ren && wen, same cycle:
//     - Different addresses: both proceed independently.
//     - Same address: read-before-write; odata gets the OLD entry and the write commits
//       (see WR_FWD_EN for the alternative).
//   Commands in CLEAR: ren/wen are ignored entirely.
//     - No array change, no ovalid, no rd_count increment.
//   rd_count: +1 per accepted read; holds at 255 (no wrap).
//   Reset mid-operation:
//     - During CLEAR: clr_ptr restarts at 0 and a full DEPTH-cycle clear runs again.
//     - During IDLE: all outputs return to reset values and the array is re-cleared.
//   X handling: no output may be X after reset, including during CLEAR.
// CONFIGURATION
//   WR_FWD_EN (macro):
//     - Defined: on a same-cycle ren&&wen to the same addr, odata gets data (write-through forwarding);
//       the array update is unchanged.
//     - Undefined (default): read-before-write as above.
//     - All other behaviour is identical with or without the macro.
// TESTING
//   1. Reset low 1 cycle, then high -> busy==1 for exactly 16 cycles.
//      Then reading each addr 0..15 returns 8'h00 with ovalid pulsed once per read.
//   2. After clear, write addr=4'h3 data=8'hA5; next cycle ren addr=3 -> following cycle odata==8'hA5,
//      ovalid==1, then ovalid==0.
//   3. With addr 5 holding 8'h11: ren=wen=1, addr=5, data=8'h22 -> odata==8'h11 without WR_FWD_EN
//      (8'h22 with it). A later read of addr 5 returns 8'h22 in both builds.
//   4. Drive ren=1 / wen=1 with data=8'hFF while busy==1 -> no ovalid, rd_count==0.
//      After clear, every entry reads 8'h00.
//   5. Issue 300 back-to-back reads -> rd_count==255 and holds; odata tracks each addressed entry.
//   6. Assert rst low at clear cycle 7, release -> busy stays high for a fresh 16 cycles.
//      Outputs are reset values meanwhile.

Source files
------------

// File: rtl/large_array_mem_if.sv
// Bus bundle for the LargeArray storage engine: command inputs and
// registered read/status outputs. The master drives commands, the slave
// (the storage engine) returns busy, read data and the read counter.
interface large_array_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) ();
  logic              ren;
  logic              wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;
  logic              busy;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [7:0]        rd_count;

  modport master (
    output ren, wen, addr, data,
    input  busy, odata, ovalid, rd_count
  );

  modport slave (
    input  ren, wen, addr, data,
    output busy, odata, ovalid, rd_count
  );
endinterface

// File: rtl/large_array_mem.sv
// LargeArray storage engine: DEPTH x DATA_W register array with a
// registered read port and a write port sharing one address. After every
// reset a clear sequencer writes INIT_VAL to each entry, holding busy high
// and ignoring commands until it finishes. Accepted reads are counted in a
// saturating 8-bit counter.
//
// Optional feature macro: WR_FWD_EN
//   defined   -> same-cycle ren&&wen returns the write data on odata
//   undefined -> same-cycle ren&&wen returns the old entry (read-before-write)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_CLEAR | sequencer writes INIT_VAL to r_mem[r_clr_ptr]; busy=1
// ST_IDLE  | reads/writes accepted; held until the next reset
module large_array_mem #(
  parameter int              DATA_W   = 8,
  parameter int              ADDR_W   = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  large_array_mem_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_busy;
  logic [DATA_W-1:0] r_odata;
  logic              r_ovalid;
  logic [7:0]        r_rd_count;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_idle;
  logic              w_rd;
  logic              w_wr;
  logic              w_fwd;
  logic [DATA_W-1:0] w_rd_data;

  assign w_idle = (r_state == ST_IDLE);
  assign w_rd   = w_idle & bus.ren;
  assign w_wr   = w_idle & bus.wen;

  // The address is shared, so a simultaneous read and write always hit the
  // same entry; forwarding therefore only depends on the write being taken.
`ifdef WR_FWD_EN
  assign w_fwd = w_wr;
`else
  assign w_fwd = 1'b0;
`endif

  // r_mem is read before this edge's write lands, giving read-before-write.
  assign w_rd_data = w_fwd ? bus.data : r_mem[bus.addr];

  // Array update: clear sequencer owns the array in ST_CLEAR, writes in ST_IDLE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      if (r_state == ST_CLEAR) begin
        r_mem[r_clr_ptr] <= INIT_VAL;
      end else if (w_wr) begin
        r_mem[bus.addr] <= bus.data;
      end
    end
  end

  // Control FSM with registered outputs: clear sequencing, read port, counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state    <= ST_CLEAR;
      r_clr_ptr  <= '0;
      r_busy     <= 1'b1;
      r_odata    <= '0;
      r_ovalid   <= 1'b0;
      r_rd_count <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_ovalid  <= 1'b0;
          r_clr_ptr <= r_clr_ptr + 1'b1;
          if (r_clr_ptr == '1) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_IDLE: begin
          r_ovalid <= w_rd;
          if (w_rd) begin
            r_odata <= w_rd_data;
            if (r_rd_count != 8'hFF) begin
              r_rd_count <= r_rd_count + 8'd1;
            end
          end
        end
        default: begin
          r_state <= ST_CLEAR;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.odata    = r_odata;
  assign bus.ovalid   = r_ovalid;
  assign bus.rd_count = r_rd_count;
endmodule

// File: tb/tb_large_array_mem.sv
// Self-checking bench for large_array_mem: directed scenarios plus
// randomized traffic compared against an array-based reference model.
module tb_large_array_mem;
  logic i_clk;
  logic i_rst;
  int   checks;
  int   errors;

  large_array_mem_if #(.DATA_W(8), .ADDR_W(4)) bus ();

  large_array_mem #(.DATA_W(8), .ADDR_W(4), .INIT_VAL(8'h00)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

`ifdef WR_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  // reference model
  logic [7:0] m_mem [16];
  logic [7:0] m_odata;
  int         m_rd_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    m_odata  = 8'h00;
    m_rd_cnt = 0;
  endtask

  // One idle-state cycle: drive command, advance, update model, compare.
  task automatic do_cycle(input bit ren, input bit wen, input logic [3:0] a, input logic [7:0] d);
    bus.ren  = ren;
    bus.wen  = wen;
    bus.addr = a;
    bus.data = d;
    tick();
    if (ren) begin
      m_odata  = (FWD && wen) ? d : m_mem[a];
      m_rd_cnt = (m_rd_cnt < 255) ? m_rd_cnt + 1 : 255;
    end
    if (wen) m_mem[a] = d;
    chk("ovalid", {31'd0, bus.ovalid}, {31'd0, ren});
    chk("odata", {24'd0, bus.odata}, {24'd0, m_odata});
    chk("rd_count", {24'd0, bus.rd_count}, m_rd_cnt);
    bus.ren = 1'b0;
    bus.wen = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_odata"}, {24'd0, bus.odata}, 32'd0);
    chk({tag, "_ovalid"}, {31'd0, bus.ovalid}, 32'd0);
    chk({tag, "_rd_count"}, {24'd0, bus.rd_count}, 32'd0);
  endtask

  // Counts busy cycles after reset release while hammering commands that
  // must be ignored; outputs must stay at reset values.
  task automatic run_clear(input string tag);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 40) begin
      bus.ren  = 1'($urandom_range(0, 1));
      bus.wen  = 1'($urandom_range(0, 1));
      bus.addr = 4'($urandom);
      bus.data = 8'hFF;
      tick();
      n++;
      chk({tag, "_clr_ovalid"}, {31'd0, bus.ovalid}, 32'd0);
      chk({tag, "_clr_rd_count"}, {24'd0, bus.rd_count}, 32'd0);
      chk({tag, "_clr_odata"}, {24'd0, bus.odata}, 32'd0);
    end
    bus.ren = 1'b0;
    bus.wen = 1'b0;
    chk({tag, "_busy_cycles"}, n, 32'd16);
    model_reset();
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    bus.ren  = 1'b0;
    bus.wen  = 1'b0;
    bus.addr = '0;
    bus.data = '0;
    i_rst    = 1'b0;
    model_reset();

    // power-on reset and clear with ignored commands
    tick();
    chk_reset_outputs("por");
    i_rst = 1'b1;
    run_clear("por");

    // every entry reads INIT_VAL
    for (int a = 0; a < 16; a++) do_cycle(1'b1, 1'b0, 4'(a), 8'h00);

    // write then read, ovalid drops afterwards
    do_cycle(1'b0, 1'b1, 4'h3, 8'hA5);
    do_cycle(1'b1, 1'b0, 4'h3, 8'h00);
    chk("a5_value", {24'd0, bus.odata}, 32'hA5);
    do_cycle(1'b0, 1'b0, 4'h0, 8'h00);

    // same-cycle read and write
    do_cycle(1'b0, 1'b1, 4'h5, 8'h11);
    do_cycle(1'b1, 1'b1, 4'h5, 8'h22);
    chk("rw_same", {24'd0, bus.odata}, FWD ? 32'h22 : 32'h11);
    do_cycle(1'b1, 1'b0, 4'h5, 8'h00);
    chk("rw_after", {24'd0, bus.odata}, 32'h22);

    // random mixed traffic
    for (int i = 0; i < 200; i++)
      do_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               4'($urandom), 8'($urandom));

    // 300 back-to-back reads saturate the counter
    for (int i = 0; i < 300; i++) do_cycle(1'b1, 1'b0, 4'($urandom), 8'h00);
    chk("rd_sat", {24'd0, bus.rd_count}, 32'd255);

    // reset from idle returns outputs and re-clears the array
    i_rst = 1'b0;
    tick();
    chk_reset_outputs("idle_rst");
    i_rst = 1'b1;
    // reset again at clear cycle 7
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("mid_busy", {31'd0, bus.busy}, 32'd1);
    end
    i_rst = 1'b0;
    tick();
    chk_reset_outputs("mid_rst");
    i_rst = 1'b1;
    run_clear("mid");
    for (int a = 0; a < 16; a++) do_cycle(1'b1, 1'b0, 4'(a), 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
